// File: rtl/pixel_frame_streamer.sv
// Raster-order frame-buffer reader driving a marked 24-bit RGB pixel stream.
// Optional internal test-pattern source: define PIXEL_FRAME_STREAMER_TPG_EN.
module pixel_frame_streamer #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 48,
    parameter int ADDR_W     = 16,
    parameter int LINE_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rd_data,
    output logic              pixel_valid_out,
    output logic [23:0]       pixel_out,
    output logic              sof,
    output logic              eol,
    output logic              eof
`ifdef PIXEL_FRAME_STREAMER_TPG_EN
    ,
    input  logic              tpg_enable
`endif
);

    localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              iss_q, iss_d;
    logic              v1_q, v1_d;
    logic              sof1_q, sof1_d;
    logic              eol1_q, eol1_d;
    logic              eof1_q, eof1_d;
    logic              pv_q, pv_d;
    logic [23:0]       pix_q, pix_d;
    logic              sof_q, sof_d;
    logic              eol_q, eol_d;
    logic              eof_q, eof_d;
    logic              done_q, done_d;
    logic              x_last, y_last;
    logic [23:0]       src_pix;

    assign x_last = (x_q == XW'(IMG_WIDTH - 1));
    assign y_last = (y_q == YW'(IMG_HEIGHT - 1));

`ifdef PIXEL_FRAME_STREAMER_TPG_EN
    logic        tpg_q;
    logic [23:0] tpix1_q;
    logic [7:0]  x8, y8;

    assign x8 = 8'(x_q);
    assign y8 = 8'(y_q);

    // Pattern is formed at issue time so it rides the same 2-cycle path as RAM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tpg_q   <= 1'b0;
            tpix1_q <= '0;
        end else begin
            if (state_q == S_IDLE && start && !abort) begin
                tpg_q <= tpg_enable;
            end
            tpix1_q <= {x8, y8, x8 + y8};
        end
    end

    assign src_pix   = tpg_q ? tpix1_q : mem_rd_data;
    assign mem_rd_en = iss_q & ~tpg_q;
`else
    assign src_pix   = mem_rd_data;
    assign mem_rd_en = iss_q;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        gap_d   = gap_q;
        iss_d   = 1'b0;
        done_d  = 1'b0;
        v1_d    = iss_q;
        sof1_d  = iss_q & (x_q == '0) & (y_q == '0);
        eol1_d  = iss_q & x_last;
        eof1_d  = iss_q & x_last & y_last;
        pv_d    = v1_q;
        pix_d   = v1_q ? src_pix : 24'h0;
        sof_d   = sof1_q;
        eol_d   = eol1_q;
        eof_d   = eof1_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_READ;
                    iss_d   = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                end
            end
            S_READ: begin
                if (x_last && y_last) begin
                    state_d = S_DRAIN;
                end else if (x_last) begin
                    x_d = '0;
                    y_d = y_q + YW'(1);
                    if (LINE_GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        iss_d  = 1'b1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else begin
                    x_d    = x_q + XW'(1);
                    iss_d  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GW'(LINE_GAP - 1)) begin
                    state_d = S_READ;
                    iss_d   = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_DRAIN: begin
                if (!v1_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase

        // Abort flushes everything already in flight.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            iss_d   = 1'b0;
            done_d  = 1'b0;
            v1_d    = 1'b0;
            sof1_d  = 1'b0;
            eol1_d  = 1'b0;
            eof1_d  = 1'b0;
            pv_d    = 1'b0;
            pix_d   = 24'h0;
            sof_d   = 1'b0;
            eol_d   = 1'b0;
            eof_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            gap_q   <= '0;
            iss_q   <= 1'b0;
            v1_q    <= 1'b0;
            sof1_q  <= 1'b0;
            eol1_q  <= 1'b0;
            eof1_q  <= 1'b0;
            pv_q    <= 1'b0;
            pix_q   <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            gap_q   <= gap_d;
            iss_q   <= iss_d;
            v1_q    <= v1_d;
            sof1_q  <= sof1_d;
            eol1_q  <= eol1_d;
            eof1_q  <= eof1_d;
            pv_q    <= pv_d;
            pix_q   <= pix_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            done_q  <= done_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign mem_addr        = addr_q;
    assign pixel_valid_out = pv_q;
    assign pixel_out       = pix_q;
    assign sof             = sof_q;
    assign eol             = eol_q;
    assign eof             = eof_q;

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Bench for pixel_frame_streamer: two DUTs (line gap 2 and 0) checked
// cycle by cycle against an arithmetic model of the frame timeline.
module tb_pixel_frame_streamer;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int AW    = 16;
    localparam int GAP_A = 2;
    localparam int GAP_B = 0;
    localparam int INF   = 1 << 30;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd;
        logic [15:0] addr;
        logic        pv;
        logic [23:0] pix;
        logic        sof;
        logic        eol;
        logic        eof;
    } ob_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
`ifdef PIXEL_FRAME_STREAMER_TPG_EN
    logic tpg_en = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [23:0] ram [0:255];

    logic          a_busy, a_done, a_rd, a_pv, a_sof, a_eol, a_eof;
    logic [AW-1:0] a_addr;
    logic [23:0]   a_rdata, a_pix;
    logic          b_busy, b_done, b_rd, b_pv, b_sof, b_eol, b_eof;
    logic [AW-1:0] b_addr;
    logic [23:0]   b_rdata, b_pix;

    always @(posedge clk) if (a_rd) a_rdata <= ram[a_addr[7:0]];
    always @(posedge clk) if (b_rd) b_rdata <= ram[b_addr[7:0]];

    pixel_frame_streamer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .LINE_GAP(GAP_A)
    ) u_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(a_busy), .done(a_done),
        .mem_rd_en(a_rd), .mem_addr(a_addr), .mem_rd_data(a_rdata),
        .pixel_valid_out(a_pv), .pixel_out(a_pix),
        .sof(a_sof), .eol(a_eol), .eof(a_eof)
`ifdef PIXEL_FRAME_STREAMER_TPG_EN
        , .tpg_enable(tpg_en)
`endif
    );

    pixel_frame_streamer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .LINE_GAP(GAP_B)
    ) u_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(b_busy), .done(b_done),
        .mem_rd_en(b_rd), .mem_addr(b_addr), .mem_rd_data(b_rdata),
        .pixel_valid_out(b_pv), .pixel_out(b_pix),
        .sof(b_sof), .eol(b_eol), .eof(b_eof)
`ifdef PIXEL_FRAME_STREAMER_TPG_EN
        , .tpg_enable(tpg_en)
`endif
    );

    int total = 0;
    int bad   = 0;

    ob_t lg [2][0:63];
    int  fs [2][4];
    int  fk [2][4];
    int  fl [2][4];
    int  fn [2];
    bit  ftpg;

    function automatic ob_t get_obs(input int d);
        ob_t o;
        if (d == 0)
            o = {a_busy, a_done, a_rd, a_addr, a_pv, a_pix, a_sof, a_eol, a_eof};
        else
            o = {b_busy, b_done, b_rd, b_addr, b_pv, b_pix, b_sof, b_eol, b_eof};
        return o;
    endfunction

    // Position p cycles into a frame's read timeline -> pixel (x,y), if any.
    function automatic bit pos_ok(input int p, input int g,
                                  output int x, output int y);
        x = 0;
        y = 0;
        if (p < 0) return 1'b0;
        y = p / (W + g);
        x = p % (W + g);
        return (y < H) && (x < W);
    endfunction

    function automatic ob_t model(input int d, input int r);
        ob_t e;
        int g, s, k, l, x, y;
        e = '0;
        g = (d == 0) ? GAP_A : GAP_B;
        for (int f = 0; f < fn[d]; f++) begin
            s = fs[d][f];
            k = fk[d][f];
            l = fl[d][f];
            if (r > s && r <= l && r <= k) e.busy = 1'b1;
            if (k == INF && r == l + 1) e.done = 1'b1;
            if (r <= k && pos_ok(r - s - 1, g, x, y) && !ftpg) begin
                e.rd   = 1'b1;
                e.addr = 16'(y * W + x);
            end
            if (r <= k && pos_ok(r - s - 3, g, x, y)) begin
                e.pv  = 1'b1;
                e.pix = ftpg ? {8'(x), 8'(y), 8'(x + y)} : ram[y * W + x];
                e.sof = (x == 0 && y == 0);
                e.eol = (x == W - 1);
                e.eof = (x == W - 1 && y == H - 1);
            end
        end
        return e;
    endfunction

    // Drives one scenario (cycle 0 = first cycle) and logs both DUTs.
    task automatic play(input int s0, input int s1, input int s2, input int s3,
                        input int ab, input int rs, input int ncyc, input bit tpg);
        int st [4];
        int be, s, l, k, g;
        st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3;
        ftpg = tpg;
        for (int d = 0; d < 2; d++) begin
            g = (d == 0) ? GAP_A : GAP_B;
            fn[d] = 0;
            be = -1;
            for (int i = 0; i < 4; i++) begin
                if (st[i] >= 0 && st[i] > be && st[i] != ab && st[i] != rs) begin
                    s = st[i];
                    l = s + 2 + W * H + (H - 1) * g;
                    k = INF;
                    if (ab > s && ab <= l) k = ab;
                    if (rs > s && rs <= l && rs < k) k = rs;
                    fs[d][fn[d]] = s;
                    fk[d][fn[d]] = k;
                    fl[d][fn[d]] = l;
                    fn[d]++;
                    be = (k < INF) ? k : l;
                end
            end
        end
        for (int r = 0; r < ncyc; r++) begin
            start = (r == s0 || r == s1 || r == s2 || r == s3);
            abort = (r == ab);
            rst   = (r == rs);
`ifdef PIXEL_FRAME_STREAMER_TPG_EN
            tpg_en = tpg;
`endif
            @(negedge clk);
            lg[0][r] = get_obs(0);
            lg[1][r] = get_obs(1);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 256; i++) ram[i] = 24'(i * 24'h010101);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) ram[i] = 24'($urandom);
    endtask

    task automatic test_reset();
        ob_t got;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                got = get_obs(d);
                total++;
                if (got !== '0) begin
                    bad++;
                    $display("FAIL reset d%0d got=%h want=0", d, got);
                end
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_frame();
        ob_t want, got;
        fill_ramp();
        play(0, -1, -1, -1, -1, -1, 16, 1'b0);
        for (int d = 0; d < 2; d++) for (int r = 0; r < 16; r++) begin
            want = model(d, r);
            got  = lg[d][r];
            if (!want.rd) got.addr = '0;
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL frame d%0d c%0d got=%h want=%h", d, r, got, want);
            end
        end
    endtask

    task automatic test_random_frames();
        ob_t want, got;
        int s;
        for (int n = 0; n < 3; n++) begin
            fill_rand();
            s = int'($urandom_range(0, 3));
            play(s, -1, -1, -1, -1, -1, 20, 1'b0);
            for (int d = 0; d < 2; d++) for (int r = 0; r < 20; r++) begin
                want = model(d, r);
                got  = lg[d][r];
                if (!want.rd) got.addr = '0;
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL rand d%0d c%0d got=%h want=%h", d, r, got, want);
                end
            end
        end
    endtask

    task automatic test_abort();
        ob_t want, got;
        int ab;
        fill_ramp();
        for (int n = 0; n < 3; n++) begin
            ab = (n == 0) ? 4 : int'($urandom_range(1, 12));
            play(0, -1, -1, -1, ab, -1, 16, 1'b0);
            for (int d = 0; d < 2; d++) for (int r = 0; r < 16; r++) begin
                want = model(d, r);
                got  = lg[d][r];
                if (!want.rd) got.addr = '0;
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL abort@%0d d%0d c%0d got=%h want=%h",
                             ab, d, r, got, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        ob_t want, got;
        fill_rand();
        play(0, 2, 7, 13, -1, -1, 32, 1'b0);
        for (int d = 0; d < 2; d++) for (int r = 0; r < 32; r++) begin
            want = model(d, r);
            got  = lg[d][r];
            if (!want.rd) got.addr = '0;
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL b2b d%0d c%0d got=%h want=%h", d, r, got, want);
            end
        end
    endtask

    task automatic test_abort_idle();
        ob_t want, got;
        fill_ramp();
        play(1, -1, -1, -1, 1, -1, 10, 1'b0);
        for (int d = 0; d < 2; d++) for (int r = 0; r < 10; r++) begin
            want = model(d, r);
            got  = lg[d][r];
            if (!want.rd) got.addr = '0;
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL abort_idle d%0d c%0d got=%h want=%h", d, r, got, want);
            end
        end
    endtask

    task automatic test_mid_reset();
        ob_t want, got;
        fill_rand();
        play(0, 8, -1, -1, -1, 5, 24, 1'b0);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (lg[d][6].addr !== 16'h0) begin
                bad++;
                $display("FAIL rst_addr d%0d got=%h want=0", d, lg[d][6].addr);
            end
            for (int r = 0; r < 24; r++) begin
                want = model(d, r);
                got  = lg[d][r];
                if (!want.rd) got.addr = '0;
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL mid_rst d%0d c%0d got=%h want=%h", d, r, got, want);
                end
            end
        end
    endtask

`ifdef PIXEL_FRAME_STREAMER_TPG_EN
    task automatic test_tpg();
        ob_t want, got;
        fill_rand();
        for (int m = 0; m < 2; m++) begin
            play(0, -1, -1, -1, -1, -1, 16, (m == 0));
            for (int d = 0; d < 2; d++) for (int r = 0; r < 16; r++) begin
                want = model(d, r);
                got  = lg[d][r];
                if (!want.rd) got.addr = '0;
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL tpg%0d d%0d c%0d got=%h want=%h",
                             m, d, r, got, want);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_random_frames();
        test_abort();
        test_back_to_back();
        test_abort_idle();
        test_mid_reset();
`ifdef PIXEL_FRAME_STREAMER_TPG_EN
        test_tpg();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_frame_streamer.md
Name: pixel_frame_streamer

Overview:
- Source end of the 24-bit RGB pixel stream interface (valid + 24-bit pixel, {R[23:16], G[15:8], B[7:0]}).
- Reads one frame from a synchronous frame-buffer RAM in raster order and drives the pixel stream into the image processing pipeline.
- Adds start-of-frame, end-of-line and end-of-frame markers, plus configurable blanking between lines.
- Controlled by a start/done handshake with abort.

Parameters:
- IMG_WIDTH, 64, pixels per line (>=1)
- IMG_HEIGHT, 48, lines per frame (>=1)
- ADDR_W, 16, RAM address width; IMG_WIDTH*IMG_HEIGHT <= 2**ADDR_W
- LINE_GAP, 4, idle cycles inserted between lines (0 = back-to-back)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  single-cycle frame request; honoured only in IDLE
- abort  input  1  synchronous cancel of the current frame
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after the last pixel of a frame
- mem_rd_en  output  1  RAM read strobe, registered
- mem_addr  output  ADDR_W  linear RAM address, registered
- mem_rd_data  input  24  RAM read data, valid one cycle after mem_rd_en
- pixel_valid_out  output  1  pixel strobe
- pixel_out  output  24  pixel data
- sof  output  1  high with the first pixel of the frame
- eol  output  1  high with the last pixel of each line
- eof  output  1  high with the last pixel of the frame

Behaviour:
- Reset: all outputs 0, mem_addr 0, FSM in IDLE, x/y counters 0, pipeline valids cleared. Reset overrides everything, including mid-frame; no done pulse is produced.
- FSM states: IDLE, READ, GAP, DRAIN.
- IDLE:
  - start=1 -> READ with x=0, y=0, addr=0.
  - start while not in IDLE is ignored.
- READ (one read per cycle):
  - mem_rd_en=1, mem_addr=y*IMG_WIDTH+x, generated by an incrementing counter (no multiplier).
  - x increments each cycle.
  - At x=IMG_WIDTH-1 and y<IMG_HEIGHT-1: x<=0, y++, then go to GAP if LINE_GAP>0, else stay in READ.
  - At the last pixel of the frame: go to DRAIN.
- GAP: mem_rd_en=0 for exactly LINE_GAP cycles, then back to READ.
- DRAIN: wait until the read pipeline is empty, then IDLE.
- Latency (start high in cycle 0):
  - mem_rd_en/addr 0 in cycle 1.
  - mem_rd_data valid in cycle 2.
  - pixel_valid_out and pixel_out (registered mem_rd_data) in cycle 3.
  - Net: pixel_valid_out is mem_rd_en delayed 2 cycles.
- Markers: sof, eol and eof are carried through the pipeline alongside valid. They are asserted only while pixel_valid_out=1. For IMG_WIDTH=1, eol is set on every pixel.
- pixel_out is 0 whenever pixel_valid_out=0.
- busy: high from cycle 1 through the cycle of the last pixel_valid_out.
- done: high for exactly the following cycle; busy=0 in that cycle.
  - start presented in the done cycle is accepted (FSM is already IDLE).
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, busy=0, mem_rd_en=0.
  - In-flight pipeline valids are cleared, so no further pixel_valid_out.
  - No done pulse.
  - abort in IDLE has no effect.
  - start and abort together in IDLE: abort wins, start is ignored.
- Frame size = IMG_WIDTH*IMG_HEIGHT valid pixels.
- Total cycles from start to done = 3 + W*H + (H-1)*LINE_GAP.

Optional Feature:
- Macro: PIXEL_FRAME_STREAMER_TPG_EN.
- Defined:
  - Extra input port tpg_enable (1 bit), sampled with start.
  - If tpg_enable=1 for the frame, mem_rd_en stays 0 for the whole frame.
  - Pixel is generated internally as {x[7:0], y[7:0], (x+y)[7:0]}.
  - Timing, markers, busy and done are identical to memory mode, including the 2-cycle latency.
- Undefined: port absent; always memory mode.

Test Plan:
- W=4, H=2, GAP=2, RAM[i]=i*0x010101, start at cycle 0 -> pixel_valid_out in cycles 3-6 and 9-12 with pixels 0x000000..0x070707 in order; sof in cycle 3; eol in cycles 6 and 12; eof in cycle 12; done in cycle 13 only; busy in cycles 1-12.
- Same config, GAP=0 -> 8 consecutive valids in cycles 3-10; done in cycle 11.
- abort asserted in cycle 4 -> mem_rd_en=0 from cycle 5; pixel_valid_out ends with last valid in cycle 4 (pixel 0x010101); no done; busy=0 in cycle 5.
- start pulses in cycles 2 and 7 during a frame -> ignored, exactly one frame produced; start in the done cycle (13) -> second frame, first valid in cycle 16.
- rst asserted in cycle 5 mid-frame -> all outputs 0 in cycle 6; FSM IDLE; no done; a new start afterwards produces a complete, correct frame.
- TPG (macro defined, tpg_enable=1), W=4, H=2 -> mem_rd_en never high; pixels 0x000000, 0x010001, 0x020002, 0x030003, 0x000101, 0x010102, ...
